// File: rtl/setn_release_seq.sv
// rtl/setn_release_seq.sv - SETN pulse / CLK_EN recovery sequencer for negative-edge set flop banks
//
// Drives the active-low SETN of a flop bank low for SET_W cycles, then holds
// the downstream clock frozen (CLK_EN=0) for REC_W more cycles, so the flops'
// minimum SETN width and SETN-to-CLKN recovery/removal windows hold by
// construction. A power-on sequence runs after reset without raising ACK;
// later sequences are requested through a 4-phase REQ/ACK handshake.
//
// Optional feature macro: SETN_STATUS_EN (adds SET_CNT and its counter).
//
// Parameters:
//   SET_W   cycles SETN held low per sequence (1..255)
//   REC_W   cycles CLK_EN held low after SETN release (1..255)
// Ports:
//   CLK      in   clock, all state on rising edge
//   RN       in   synchronous active-low reset
//   REQ      in   set request level (4-phase handshake)
//   ACK      out  sequence complete, held until REQ is seen low
//   SETN     out  active-low set to the flop bank (registered)
//   CLK_EN   out  0 = downstream CLKN must be held high (registered)
//   BUSY     out  sequence in progress (registered)
//   SET_CNT  out  saturating count of completed handshake sequences
//                 (SETN_STATUS_EN only)

module setn_release_seq #(
    parameter int unsigned SET_W = 2,
    parameter int unsigned REC_W = 2
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       REQ,
    output logic       ACK,
    output logic       SETN,
    output logic       CLK_EN,
`ifdef SETN_STATUS_EN
    output logic [7:0] SET_CNT,
`endif
    output logic       BUSY
);

    localparam logic [7:0] SET_LOAD = 8'(SET_W - 1);
    localparam logic [7:0] REC_LOAD = 8'(REC_W - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RECOVER = 2'd1,
        ST_IDLE    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic       por, por_d;
    logic       setn_d, clk_en_d, busy_d, ack_d;

    always_ff @(posedge CLK) begin
        if (!RN) begin
            state  <= ST_ASSERT;
            cnt    <= SET_LOAD;
            por    <= 1'b1;
            SETN   <= 1'b0;
            CLK_EN <= 1'b0;
            BUSY   <= 1'b1;
            ACK    <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            por    <= por_d;
            SETN   <= setn_d;
            CLK_EN <= clk_en_d;
            BUSY   <= busy_d;
            ACK    <= ack_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        por_d   = por;
        case (state)
            ST_ASSERT: begin
                if (cnt == 8'd0) begin
                    state_d = ST_RECOVER;
                    cnt_d   = REC_LOAD;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            ST_RECOVER: begin
                if (cnt == 8'd0) begin
                    // The power-on sequence has no requester to acknowledge.
                    if (por) begin
                        state_d = ST_IDLE;
                        por_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end
            ST_IDLE: begin
                if (REQ) begin
                    state_d = ST_ASSERT;
                    cnt_d   = SET_LOAD;
                end
            end
            ST_DONE: begin
                if (!REQ) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so they
        // switch on the same edge as the state. ASSERT is only entered from
        // IDLE/reset and left to RECOVER, so SETN falling and CLK_EN rising
        // can never share an edge.
        setn_d   = (state_d != ST_ASSERT);
        clk_en_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d   = (state_d == ST_ASSERT) || (state_d == ST_RECOVER);
        ack_d    = (state_d == ST_DONE);
    end

`ifdef SETN_STATUS_EN
    logic seq_done;
    assign seq_done = (state == ST_RECOVER) && (state_d == ST_DONE);

    always_ff @(posedge CLK) begin
        if (!RN) begin
            SET_CNT <= 8'd0;
        end else if (seq_done && (SET_CNT != 8'hFF)) begin
            SET_CNT <= SET_CNT + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_setn_release_seq.sv
// tb/tb_setn_release_seq.sv - self-checking bench for setn_release_seq (two width configurations)

module tb_setn_release_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rn  = 1'b0;
    logic req = 1'b0;

    logic ack3, setn3, clken3, busy3;
    logic ack1, setn1, clken1, busy1;
`ifdef SETN_STATUS_EN
    logic [7:0] cnt3, cnt1;
`endif

    setn_release_seq #(.SET_W(3), .REC_W(2)) u_w3 (
        .CLK    (clk),
        .RN     (rn),
        .REQ    (req),
        .ACK    (ack3),
        .SETN   (setn3),
        .CLK_EN (clken3),
`ifdef SETN_STATUS_EN
        .SET_CNT(cnt3),
`endif
        .BUSY   (busy3)
    );

    setn_release_seq #(.SET_W(1), .REC_W(1)) u_w1 (
        .CLK    (clk),
        .RN     (rn),
        .REQ    (req),
        .ACK    (ack1),
        .SETN   (setn1),
        .CLK_EN (clken1),
`ifdef SETN_STATUS_EN
        .SET_CNT(cnt1),
`endif
        .BUSY   (busy1)
    );

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc_n     = 0;

    // Reference: a sequence is an age (edges since it started); SETN low for
    // ages 0..SW-1, clock frozen until age SW+RW, then done (if requested).
    int sw [2] = '{3, 1};
    int rw [2] = '{2, 1};
    int age    [2];
    bit por_m  [2];
    bit done_m [2];
    int cnt_m  [2];

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                age[i]    = 0;
                por_m[i]  = 1'b1;
                done_m[i] = 1'b0;
                cnt_m[i]  = 0;
            end else if (age[i] >= 0) begin
                age[i]++;
                if (age[i] == sw[i] + rw[i]) begin
                    age[i] = -1;
                    if (!por_m[i]) begin
                        done_m[i] = 1'b1;
                        if (cnt_m[i] < 255) cnt_m[i]++;
                    end
                    por_m[i] = 1'b0;
                end
            end else if (done_m[i]) begin
                if (!req) done_m[i] = 1'b0;
            end else if (req) begin
                age[i]   = 0;
                por_m[i] = 1'b0;
            end
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_asserts++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    task automatic check_all();
        chk1("w3_setn",  setn3,  !(age[0] >= 0 && age[0] < sw[0]));
        chk1("w3_clken", clken3, age[0] < 0);
        chk1("w3_busy",  busy3,  age[0] >= 0);
        chk1("w3_ack",   ack3,   done_m[0]);
        chk1("w1_setn",  setn1,  !(age[1] >= 0 && age[1] < sw[1]));
        chk1("w1_clken", clken1, age[1] < 0);
        chk1("w1_busy",  busy1,  age[1] >= 0);
        chk1("w1_ack",   ack1,   done_m[1]);
`ifdef SETN_STATUS_EN
        chk8("w3_cnt", cnt3, 8'(cnt_m[0]));
        chk8("w1_cnt", cnt1, 8'(cnt_m[1]));
`endif
    endtask

    // One clock: model follows the rising edge, DUT checked on the falling edge.
    task automatic cyc(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk);
            model_step();
            cyc_n++;
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        // Reset held for 3 cycles.
        rn = 1'b0; req = 1'b0;
        cyc(3);
        chk1("rst_setn",  setn3,  1'b0);
        chk1("rst_clken", clken3, 1'b0);
        chk1("rst_busy",  busy3,  1'b1);
        chk1("rst_ack",   ack3,   1'b0);

        // Power-on sequence completes with no ACK.
        rn = 1'b1;
        cyc(8);
        chk1("por_idle_clken", clken3, 1'b1);
        chk1("por_no_ack",     ack3,   1'b0);

        // Plain handshake.
        req = 1'b1; cyc(7);
        req = 1'b0; cyc(3);

        // REQ glitching during ASSERT/RECOVER.
        req = 1'b1; cyc(1);
        req = 1'b0; cyc(1);
        req = 1'b1; cyc(2);
        req = 1'b0; cyc(1);
        req = 1'b1; cyc(3);
        req = 1'b0; cyc(3);

        // Reset in the middle of a sequence.
        req = 1'b1; cyc(3);
        rn  = 1'b0; cyc(1);
        chk1("midrst_setn",  setn3,  1'b0);
        chk1("midrst_clken", clken3, 1'b0);
        rn  = 1'b1; req = 1'b0; cyc(8);

        // Back-to-back handshakes with a one-cycle REQ low gap (SET_W=REC_W=1).
        for (int j = 0; j < 40; j++) begin
            req = !ack1;
            cyc(1);
        end
        req = 1'b0; cyc(6);

        // Random REQ with occasional reset.
        for (int j = 0; j < 2000; j++) begin
            req = 1'($urandom);
            rn  = ($urandom_range(0, 99) != 0);
            cyc(1);
        end

`ifdef SETN_STATUS_EN
        // Enough handshakes to saturate both counters.
        rn = 1'b0; req = 1'b0; cyc(2);
        rn = 1'b1;
        for (int j = 0; j < 2400; j++) begin
            req = !ack3;
            cyc(1);
        end
        chk8("w3_cnt_sat", cnt3, 8'd255);
        chk8("w1_cnt_sat", cnt1, 8'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
